// File: rtl/ir_pkg.sv
// ----------------------------------------------------------------------------
// ir_pkg -- shared definitions for the NEC infrared receive path.
//
// Holds the NEC nominal pulse widths (microseconds), the one-hot decoder
// state encoding, the default width tolerance and helpers that turn a
// width in microseconds into clock cycles and tolerance windows.
// No ports (package).
// ----------------------------------------------------------------------------
package ir_pkg;

   // NEC nominal widths in microseconds
   localparam int unsigned NEC_LEAD_US    = 9000;
   localparam int unsigned NEC_SPACE_US   = 4500;
   localparam int unsigned NEC_RPT_US     = 2250;
   localparam int unsigned NEC_BURST_US   = 560;
   localparam int unsigned NEC_ZERO_US    = 560;
   localparam int unsigned NEC_ONE_US     = 1690;
   localparam int unsigned NEC_TIMEOUT_US = 12000;
   localparam int unsigned NEC_RPTGAP_US  = 110000;

   localparam int unsigned TOL_PCT_DEF    = 25;

   typedef enum logic [5:0] {
      ST_IDLE      = 6'b000001,
      ST_LEAD      = 6'b000010,
      ST_SPACE     = 6'b000100,
      ST_BIT_MARK  = 6'b001000,
      ST_BIT_SPACE = 6'b010000,
      ST_RPT_STOP  = 6'b100000
   } state_e;

   // Microseconds to clock cycles, 64-bit so large clocks do not overflow.
   function automatic longint unsigned us_to_cyc(input longint unsigned us,
                                                 input longint unsigned clk_hz);
      return (us * clk_hz) / 64'd1_000_000;
   endfunction

   function automatic longint unsigned win_lo(input longint unsigned cyc,
                                              input int unsigned tol);
      return (cyc * (100 - tol)) / 100;
   endfunction

   function automatic longint unsigned win_hi(input longint unsigned cyc,
                                              input int unsigned tol);
      return (cyc * (100 + tol)) / 100;
   endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// ----------------------------------------------------------------------------
// ir_edge_sync -- brings the raw IR receiver output into the clk domain and
// produces single-cycle fall/rise pulses plus the cleaned line level.
//
// Optional feature macro: IR_GLITCH_FILTER_EN
//   defined   : an 8-sample majority filter, sampled at a 1 us prescale,
//               sits between the synchroniser and the edge detector, so
//               pulses shorter than about 5 us never reach the decoder.
//   undefined : the synchroniser output feeds the edge detector directly.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   din_i    in   raw IR line (idle high), asynchronous to clk
//   fall_o   out  1-cycle pulse on a high-to-low transition
//   rise_o   out  1-cycle pulse on a low-to-high transition
//   level_o  out  synchronised (and optionally filtered) line level
// ----------------------------------------------------------------------------
module ir_edge_sync #(
   parameter int unsigned SYNC_STAGES = 3,
   parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_i,
   output logic fall_o,
   output logic rise_o,
   output logic level_o
);

   // Reset to the idle-high level so releasing reset never fakes a fall.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   src;
   logic                   last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      end
   end

`ifdef IR_GLITCH_FILTER_EN
   localparam int unsigned PRE   = (CLK_FREQ_HZ >= 2_000_000) ? (CLK_FREQ_HZ / 1_000_000) : 1;
   localparam int          PRE_W = (PRE > 1) ? $clog2(PRE) : 1;

   logic [PRE_W-1:0] pre_q;
   logic [7:0]       win_q;
   logic             filt_q;
   logic             tick;
   logic [3:0]       ones;

   assign tick = (pre_q == PRE_W'(PRE - 1));
   assign ones = 4'($countones(win_q));

   // A 4/4 split keeps the previous level, giving a little hysteresis.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         win_q  <= '1;
         filt_q <= 1'b1;
      end else begin
         pre_q <= tick ? '0 : pre_q + PRE_W'(1);
         if (tick) begin
            win_q <= {win_q[6:0], sync_q[SYNC_STAGES-1]};
         end
         if (ones > 4'd4) begin
            filt_q <= 1'b1;
         end else if (ones < 4'd4) begin
            filt_q <= 1'b0;
         end
      end
   end

   assign src = filt_q;
`else
   assign src = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= src;
      end
   end

   assign fall_o  =  last_q & ~src;
   assign rise_o  = ~last_q &  src;
   assign level_o =  src;

endmodule

// File: rtl/ir_nec_rx.sv
// ----------------------------------------------------------------------------
// ir_nec_rx -- NEC infrared frame receiver.
//
// Measures the low/high widths of the demodulated IR line, decodes 32-bit
// NEC frames (LSB first) into address and command, checks the command
// (and optionally address) complement bytes, recognises repeat codes and
// aborts stalled frames after 12 ms without an edge.
// Optional glitch filter in ir_edge_sync: macro IR_GLITCH_FILTER_EN.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ir_din   in   raw IR receiver output (idle high, bursts low)
//   ir_addr  out  address of last good frame ({8'h00,byte0} when ADDR_EXT=0)
//   ir_cmd   out  command of last good frame
//   ir_vld   out  1-cycle strobe, new checked frame on ir_addr/ir_cmd
//   ir_err   out  1-cycle strobe, frame aborted (width, timeout, checksum)
//   ir_rpt   out  1-cycle strobe, repeat code after a good frame
//   ir_busy  out  high while a frame is in progress
// ----------------------------------------------------------------------------
module ir_nec_rx
   import ir_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned SYNC_STAGES = 3,
   parameter int unsigned TOL_PCT     = TOL_PCT_DEF,
   parameter bit          ADDR_EXT    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ir_din,
   output logic [15:0] ir_addr,
   output logic [7:0]  ir_cmd,
   output logic        ir_vld,
   output logic        ir_err,
   output logic        ir_rpt,
   output logic        ir_busy
);

   localparam longint unsigned TO_CYC  = us_to_cyc(NEC_TIMEOUT_US, CLK_FREQ_HZ);
   localparam longint unsigned GAP_CYC = us_to_cyc(NEC_RPTGAP_US, CLK_FREQ_HZ);
   localparam int CNT_W = $clog2(TO_CYC) + 1;
   localparam int WW    = CNT_W + 1;
   localparam int GAP_W = $clog2(GAP_CYC) + 1;

   localparam longint unsigned LEAD_C  = us_to_cyc(NEC_LEAD_US,  CLK_FREQ_HZ);
   localparam longint unsigned SPACE_C = us_to_cyc(NEC_SPACE_US, CLK_FREQ_HZ);
   localparam longint unsigned RPT_C   = us_to_cyc(NEC_RPT_US,   CLK_FREQ_HZ);
   localparam longint unsigned BURST_C = us_to_cyc(NEC_BURST_US, CLK_FREQ_HZ);
   localparam longint unsigned ZERO_C  = us_to_cyc(NEC_ZERO_US,  CLK_FREQ_HZ);
   localparam longint unsigned ONE_C   = us_to_cyc(NEC_ONE_US,   CLK_FREQ_HZ);

   localparam logic [WW-1:0] LEAD_LO  = WW'(win_lo(LEAD_C,  TOL_PCT));
   localparam logic [WW-1:0] LEAD_HI  = WW'(win_hi(LEAD_C,  TOL_PCT));
   localparam logic [WW-1:0] SPACE_LO = WW'(win_lo(SPACE_C, TOL_PCT));
   localparam logic [WW-1:0] SPACE_HI = WW'(win_hi(SPACE_C, TOL_PCT));
   localparam logic [WW-1:0] RPT_LO   = WW'(win_lo(RPT_C,   TOL_PCT));
   localparam logic [WW-1:0] RPT_HI   = WW'(win_hi(RPT_C,   TOL_PCT));
   localparam logic [WW-1:0] BURST_LO = WW'(win_lo(BURST_C, TOL_PCT));
   localparam logic [WW-1:0] BURST_HI = WW'(win_hi(BURST_C, TOL_PCT));
   localparam logic [WW-1:0] ZERO_LO  = WW'(win_lo(ZERO_C,  TOL_PCT));
   localparam logic [WW-1:0] ZERO_HI  = WW'(win_hi(ZERO_C,  TOL_PCT));
   localparam logic [WW-1:0] ONE_LO   = WW'(win_lo(ONE_C,   TOL_PCT));
   localparam logic [WW-1:0] ONE_HI   = WW'(win_hi(ONE_C,   TOL_PCT));

   localparam logic [CNT_W-1:0] TO_Q  = CNT_W'(TO_CYC);
   localparam logic [GAP_W-1:0] GAP_Q = GAP_W'(GAP_CYC);

   function automatic logic in_win(input logic [WW-1:0] w,
                                   input logic [WW-1:0] lo,
                                   input logic [WW-1:0] hi);
      return (w >= lo) && (w <= hi);
   endfunction

   logic fall;
   logic rise;
   logic level_unused;   // line level is not needed by the decoder itself

   ir_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .CLK_FREQ_HZ (CLK_FREQ_HZ)
   ) u_edge_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_i   (ir_din),
      .fall_o  (fall),
      .rise_o  (rise),
      .level_o (level_unused)
   );

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [4:0]       bit_idx_q;
   logic [31:0]      sr_q;
   logic             rpt_ok_q;
   logic [15:0]      addr_q;
   logic [7:0]       cmd_q;
   logic             vld_q, err_q, rpt_q;

   logic [WW-1:0] width;
   logic          one_hit, zero_hit;
   logic [31:0]   sr_shift;
   logic          cs_ok;
   logic          timeout;
   logic          gap_exp;

   // Width counter: restarts on every edge, parked at zero in IDLE and
   // saturating so a stuck line cannot wrap back into a valid window.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE || fall || rise) begin
         cnt_d = '0;
      end else if (!(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Repeat-allow window: runs only while rpt_ok is set and restarts after
   // each good frame or accepted repeat.
   always_comb begin
      gap_d = gap_q;
      if (!rpt_ok_q || vld_q || rpt_q) begin
         gap_d = '0;
      end else if (gap_q != GAP_Q) begin
         gap_d = gap_q + GAP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         gap_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         gap_q <= gap_d;
      end
   end

   // cnt_q lags the edge by one cycle, so +1 gives the exact pulse width.
   assign width    = {1'b0, cnt_q} + WW'(1);
   assign one_hit  = in_win(width, ONE_LO, ONE_HI);
   assign zero_hit = in_win(width, ZERO_LO, ZERO_HI);
   assign sr_shift = {one_hit, sr_q[31:1]};
   assign cs_ok    = (sr_shift[31:24] == ~sr_shift[23:16]) &&
                     (ADDR_EXT || (sr_shift[15:8] == ~sr_shift[7:0]));
   assign timeout  = (cnt_q >= TO_Q);
   assign gap_exp  = rpt_ok_q && (gap_q == GAP_Q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= '0;
         sr_q      <= '0;
         rpt_ok_q  <= 1'b0;
         addr_q    <= '0;
         cmd_q     <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         rpt_q     <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         err_q <= 1'b0;
         rpt_q <= 1'b0;
         if (gap_exp) begin
            rpt_ok_q <= 1'b0;
         end

         if (state_q != ST_IDLE && timeout) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b1;
            rpt_ok_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (fall) begin
                     state_q <= ST_LEAD;
                  end
               end
               ST_LEAD: begin
                  if (rise) begin
                     if (in_win(width, LEAD_LO, LEAD_HI)) begin
                        state_q <= ST_SPACE;
                     end else begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               end
               ST_SPACE: begin
                  if (fall) begin
                     if (in_win(width, SPACE_LO, SPACE_HI)) begin
                        state_q   <= ST_BIT_MARK;
                        bit_idx_q <= '0;
                     end else if (in_win(width, RPT_LO, RPT_HI)) begin
                        state_q <= ST_RPT_STOP;
                     end else begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               end
               ST_BIT_MARK: begin
                  if (rise) begin
                     if (in_win(width, BURST_LO, BURST_HI)) begin
                        state_q <= ST_BIT_SPACE;
                     end else begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               end
               ST_BIT_SPACE: begin
                  if (fall) begin
                     if (one_hit || zero_hit) begin
                        sr_q <= sr_shift;
                        if (bit_idx_q == 5'd31) begin
                           state_q <= ST_IDLE;
                           if (cs_ok) begin
                              addr_q   <= ADDR_EXT ? sr_shift[15:0] : {8'h00, sr_shift[7:0]};
                              cmd_q    <= sr_shift[23:16];
                              vld_q    <= 1'b1;
                              rpt_ok_q <= 1'b1;
                           end else begin
                              err_q    <= 1'b1;
                              rpt_ok_q <= 1'b0;
                           end
                        end else begin
                           bit_idx_q <= bit_idx_q + 5'd1;
                           state_q   <= ST_BIT_MARK;
                        end
                     end else begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                     end
                  end
               end
               ST_RPT_STOP: begin
                  if (rise) begin
                     state_q <= ST_IDLE;
                     if (in_win(width, BURST_LO, BURST_HI)) begin
                        rpt_q <= rpt_ok_q && !gap_exp;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign ir_addr = addr_q;
   assign ir_cmd  = cmd_q;
   assign ir_vld  = vld_q;
   assign ir_err  = err_q;
   assign ir_rpt  = rpt_q;
   assign ir_busy = (state_q != ST_IDLE);

endmodule
